// File: rtl/seq_mult_pkg.sv
// Shared constants and FSM state type for the chunked sequential multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_mult_pkg;

    // Width of one operand chunk fed to the shared 8x8 multiplier
    localparam int CHUNK_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/chunk_mult_u8.sv
// Unsigned CHUNK_W x CHUNK_W -> 2*CHUNK_W combinational multiplier.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
module chunk_mult_u8
    import seq_mult_pkg::*;
(
    input  logic [CHUNK_W-1:0]   a,
    input  logic [CHUNK_W-1:0]   b,
    output logic [2*CHUNK_W-1:0] p
);

    assign p = (2*CHUNK_W)'(a) * (2*CHUNK_W)'(b);

endmodule

// File: rtl/seq_mult_nbit.sv
// Sequential signed/unsigned DATA_W x DATA_W multiplier built from one shared 8x8 unit.
// Latency: capture edge T -> o_valid after edge T+NPP+1 (T+1 for zero operands when SEQ_MULT_ZERO_SKIP_EN).
// Backpressure: o_ready only in IDLE; result held in DONE until i_ready, one operation in flight.
// Optional feature macro: SEQ_MULT_ZERO_SKIP_EN (zero operand bypasses CALC).
module seq_mult_nbit
    import seq_mult_pkg::*;
#(
    parameter int DATA_W = 16
)
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    input  logic                i_signed,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [2*DATA_W-1:0] o_z
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int NPP    = NCHUNK * NCHUNK;
    localparam int CNT_W  = $clog2(NCHUNK);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NCHUNK - 1);

    state_t               state_q;
    state_t               state_d;
    logic [DATA_W-1:0]    mag_a_q;
    logic [DATA_W-1:0]    mag_b_q;
    logic                 sign_q;
    logic [PROD_W-1:0]    acc_q;
    logic [CNT_W-1:0]     ci_q;
    logic [CNT_W-1:0]     cj_q;

    logic                 capture;
    logic                 step;
    logic                 fix;
    logic                 ack;
    logic                 last_pp;

    logic [DATA_W-1:0]    abs_a;
    logic [DATA_W-1:0]    abs_b;
    logic [CHUNK_W-1:0]   chunk_a;
    logic [CHUNK_W-1:0]   chunk_b;
    logic [2*CHUNK_W-1:0] pp;
    logic [PROD_W-1:0]    pp_shift;

    // Magnitudes of the incoming operands; the most negative value maps onto
    // 2^(DATA_W-1), which still fits unsigned in DATA_W bits.
    always_comb begin
        abs_a = i_a;
        abs_b = i_b;
        if (i_signed && i_a[DATA_W-1]) abs_a = (~i_a) + DATA_W'(1);
        if (i_signed && i_b[DATA_W-1]) abs_b = (~i_b) + DATA_W'(1);
    end

    assign last_pp = (ci_q == CNT_MAX) && (cj_q == CNT_MAX);

    // Select the current chunk pair and align its partial product to 8*(i+j)
    always_comb begin
        chunk_a  = mag_a_q[ci_q*CHUNK_W +: CHUNK_W];
        chunk_b  = mag_b_q[cj_q*CHUNK_W +: CHUNK_W];
        pp_shift = PROD_W'(pp) << (CHUNK_W * (int'(ci_q) + int'(cj_q)));
    end

    chunk_mult_u8 u_chunk_mult (
        .a (chunk_a),
        .b (chunk_b),
        .p (pp)
    );

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and per-state datapath enables
    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        capture = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        ack     = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    capture = 1'b1;
                    state_d = CALC;
`ifdef SEQ_MULT_ZERO_SKIP_EN
                    // A zero magnitude means a zero product: the cleared accumulator is already the answer
                    if ((abs_a == '0) || (abs_b == '0)) state_d = FIX;
`endif
                end
            end
            CALC: begin
                step = 1'b1;
                if (last_pp) state_d = FIX;
            end
            FIX: begin
                fix     = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (i_ready) begin
                    ack     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, partial-product accumulation, sign fix-up and result hold
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mag_a_q <= '0;
            mag_b_q <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            ci_q    <= '0;
            cj_q    <= '0;
            o_z     <= '0;
            o_valid <= 1'b0;
        end else begin
            if (capture) begin
                mag_a_q <= abs_a;
                mag_b_q <= abs_b;
                sign_q  <= i_signed & (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
                acc_q   <= '0;
            end
            if (step) begin
                acc_q <= acc_q + pp_shift;
                // j is the inner index; both wrap to 0 after the last pair
                if (cj_q == CNT_MAX) begin
                    cj_q <= '0;
                    ci_q <= (ci_q == CNT_MAX) ? '0 : ci_q + CNT_W'(1);
                end else begin
                    cj_q <= cj_q + CNT_W'(1);
                end
            end
            if (fix) begin
                o_z     <= sign_q ? (~acc_q + PROD_W'(1)) : acc_q;
                o_valid <= 1'b1;
            end
            if (ack) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_nbit.sv
// Randomised scoreboard bench for seq_mult_nbit (DATA_W=16).
// Latency: checks o_valid rise against the capture edge of each operation.
// Backpressure: randomised i_ready, plus a held-off DONE window and a mid-CALC reset.
module tb_seq_mult_nbit;

    localparam int W   = 16;
    localparam int NPP = (W / 8) * (W / 8);

    typedef struct {
        logic [2*W-1:0] z;
        int             cap;
        int             lat;
    } exp_t;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic           i_valid;
    logic           o_ready;
    logic [W-1:0]   i_a;
    logic [W-1:0]   i_b;
    logic           i_signed;
    logic           o_valid;
    logic           i_ready = 1'b0;
    logic [2*W-1:0] o_z;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   rdy_mode = 0;     // 0 random, 1 hold low, 2 hold high
    exp_t sb[$];
    logic prev_valid = 1'b0;
    logic [2*W-1:0] held_z = '0;

    seq_mult_nbit #(.DATA_W(W)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_signed (i_signed),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_z      (o_z)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer product with operands extended by sign or zero
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic signed [2*W+1:0] ea;
        logic signed [2*W+1:0] eb;
        logic signed [2*W+1:0] p;
        ea = s ? {{(W+2){a[W-1]}}, a} : {{(W+2){1'b0}}, a};
        eb = s ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
        p  = ea * eb;
        return p[2*W-1:0];
    endfunction

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MULT_ZERO_SKIP_EN
        if (a == '0 || b == '0) return 1;
`endif
        return NPP + 1;
    endfunction

    always @(negedge i_clk) begin
        case (rdy_mode)
            0:       i_ready = ($urandom_range(0, 3) != 0);
            1:       i_ready = 1'b0;
            default: i_ready = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on each new result and watches hold behaviour
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst === 1'b1) begin
            check("rst_o_valid", 64'(o_valid), 64'd0);
            check("rst_o_z", 64'(o_z), 64'd0);
            check("rst_o_ready", 64'(o_ready), 64'd1);
            prev_valid = 1'b0;
        end else if (i_rst === 1'b0) begin
            if (o_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 64'(o_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("product", 64'(o_z), 64'(e.z));
                    check("latency", 64'(cyc - e.cap), 64'(e.lat));
                    check("busy_ready", 64'(o_ready), 64'd0);
                end
                held_z = o_z;
            end else if (o_valid) begin
                check("hold_o_z", 64'(o_z), 64'(held_z));
                check("hold_ready", 64'(o_ready), 64'd0);
            end
            prev_valid = o_valid;
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
        int n;
        exp_t e;
        n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) begin
            check("wait_ready_timeout", 64'(o_ready), 64'd1);
            return;
        end
        i_a      = a;
        i_b      = b;
        i_signed = s;
        i_valid  = 1'b1;
        if (push) begin
            e.z   = ref_mul(a, b, s);
            e.cap = cyc + 1;
            e.lat = exp_lat(a, b);
            sb.push_back(e);
        end
        @(negedge i_clk);
        i_valid  = 1'b0;
        i_a      = W'($urandom);
        i_b      = W'($urandom);
        i_signed = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !o_ready) && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h7FFF;
            4:       return 16'h0001;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        exp_t e;
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_a      = '0;
        i_b      = '0;
        i_signed = 1'b0;
        repeat (3) @(negedge i_clk);
        #1 i_rst = 1'b0;

        // Directed corner products
        do_op(16'hFFFD, 16'h0005, 1'b1, 1'b1);
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        do_op(16'h8000, 16'h8000, 1'b1, 1'b1);
        do_op(16'h7FFF, 16'h8000, 1'b1, 1'b1);
        do_op(16'h0000, 16'h1234, 1'b0, 1'b1);
        do_op(16'h1234, 16'h0000, 1'b1, 1'b1);
        drain();

        // Result held off for 10 cycles while a new request waits
        @(posedge i_clk);
        rdy_mode = 1;
        do_op(16'h00FF, 16'hFF01, 1'b1, 1'b1);
        n = 0;
        while (!o_valid && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("bp_valid_seen", 64'(o_valid), 64'd1);
        i_a      = 16'hBEEF;
        i_b      = 16'h0123;
        i_signed = 1'b0;
        i_valid  = 1'b1;
        repeat (10) @(negedge i_clk);
        @(posedge i_clk);
        rdy_mode = 2;
        @(negedge i_clk);
        e.z   = ref_mul(16'hBEEF, 16'h0123, 1'b0);
        e.cap = cyc + 2;
        e.lat = NPP + 1;
        sb.push_back(e);
        @(negedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(posedge i_clk);
        rdy_mode = 0;
        drain();

        // Reset during the second CALC cycle abandons the operation
        do_op(16'h1234, 16'h5678, 1'b0, 1'b1);
        drain();
        do_op(16'hABCD, 16'h0011, 1'b0, 1'b0);
        @(negedge i_clk);
        #1 i_rst = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        #1 i_rst = 1'b0;
        do_op(16'hABCD, 16'h0011, 1'b0, 1'b1);
        drain();

        // Randomised operands and modes
        for (int k = 0; k < 40; k++) begin
            do_op(pick(), pick(), 1'($urandom), 1'b1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
